text_pixel_gen: RTL
===================

// Module: text_pixel_gen
// PURPOSE
//  Pixel-generation stage that sits directly downstream of the 640x480 VGA timing controller.
//  Consumes the pixel tick, x/y counts, video_on and hsync/vsync, and renders the fixed string
//  "HELLO WORLD" plus a blinking block cursor from an internal 8x16 font ROM.
//  Drives the Basys3 12-bit RGB and sync pins, with syncs delayed to match the pixel pipeline.
// PARAMETERS
//  TEXT_X0       256      left edge of the text box, in pixels
//  TEXT_Y0       232      top edge of the text box, in pixels
//  SCALE_LOG2    1        glyph scale = 2**SCALE_LOG2; default cell is 16x32
//  NUM_CHARS     11       number of string characters; cursor occupies cell NUM_CHARS
//  BLINK_FRAMES  30       frames per cursor blink half-period, >=1
//  FG_RGB        12'hFFF  colour of a set glyph pixel
//  BG_RGB        12'h000  colour of an active pixel with no glyph bit set
// PORTS
//  clk_100MHz  in   1   system clock
//  reset_n     in   1   asynchronous, active-low reset
//  p_tick      in   1   pixel enable, 1 clk in 4
//  video_on    in   1   display-area flag from the timing controller
//  hsync_in    in   1   hsync from the timing controller, active-high in retrace
//  vsync_in    in   1   vsync from the timing controller, active-high in retrace
//  x           in   10  pixel column, 0-799
//  y           in   10  pixel row, 0-524
//  hsync       out  1   hsync_in delayed 3 pixel ticks
//  vsync       out  1   vsync_in delayed 3 pixel ticks
//  rgb         out  12  {R[3:0],G[3:0],B[3:0]}
//  frame_start out  1   one-clk pulse on each vsync_in rising edge
// BEHAVIOUR
//  - Reset (reset_n=0, async): rgb=0, hsync=0, vsync=0, frame_start=0.
//    All pipeline registers, the frame counter and the blink state are cleared to 0 (cursor off).
//  - Pipeline state advances only on clk edges where p_tick=1; on other clks it holds.
//    frame_start is the only exception.
//  - Latency: exactly 3 p_ticks from the inputs to rgb/hsync/vsync. video_on travels with the data.
//  - S1 (p_tick #1):
//    - dx = {1'b0,x} - TEXT_X0 and dy = {1'b0,y} - TEXT_Y0, both 11-bit. A negative result means outside the box.
//    - in_box = dx < (NUM_CHARS+1)*8<<SCALE_LOG2 AND dy < 16<<SCALE_LOG2.
//    - cell = dx >> (3+SCALE_LOG2); col = (dx>>SCALE_LOG2)[2:0]; row = (dy>>SCALE_LOG2)[3:0].
//    - Register cell, col, row, in_box, video_on, hsync_in and vsync_in.
//  - S2 (p_tick #2):
//    - String ROM maps cell to glyph code: H,E,L,O,space,W,R,D.
//    - Cell NUM_CHARS maps to the cursor glyph (all rows 8'hFF).
//    - Font ROM (IBM VGA 8x16 rows) returns an 8-bit row byte, registered with col and the flags.
//  - S3 (p_tick #3):
//    - pix = byte[7-col], so the MSB is the leftmost pixel.
//    - The cursor cell uses pix &= blink.
//    - rgb = !video_on ? 0 : (in_box & pix) ? FG_RGB : BG_RGB.
//    - hsync and vsync take their S2 copies.
//  - Blanking has priority: video_on=0 always forces rgb=0, even inside the box.
//  - Frame and blink:
//    - vsync_in is sampled every clk into vs_d; frame_start = vsync_in & ~vs_d.
//    - On frame_start, frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and blink toggles.
//  - Reset mid-frame: outputs drop immediately. After release, rgb/syncs are 0 for 3 p_ticks,
//    then track the inputs. The blink phase restarts with the cursor off.
//  - No handshake: the block is a free-running stream slaved to p_tick and cannot stall upstream.
// TESTING
//  1 Reset: reset_n=0 with rgb driving FFF -> rgb=000, hsync=vsync=0 in the same clk.
//    Release -> rgb stays 000 for the first 3 p_ticks.
//  2 Glyph: video_on=1, x=256, y=236 ('H' row 2 = 8'hC6) -> rgb=FFF 3 p_ticks later.
//    x=260 (col 2) -> rgb=000 (BG).
//  3 Blanking: video_on=0, x=256, y=236 -> rgb=000.
//    x=255 or y=231 with video_on=1 -> rgb=BG_RGB.
//  4 Sync alignment: 96-tick hsync_in pulse -> hsync is 96 ticks wide, starting exactly 3 p_ticks later.
//    Same check for a 2-line vsync.
//  5 Blink: BLINK_FRAMES=2, x=432, y=240 in the cursor cell, 6 vsync_in rising edges
//    -> 6 frame_start pulses of 1 clk each; cursor rgb sequence per frame is 000,000,FFF,FFF,000,000.
//  6 Wrap: frame_cnt at BLINK_FRAMES-1 plus one vsync edge -> frame_cnt=0 and blink toggles.
//    Reset mid-blink -> blink=0 and frame_cnt=0.

Source files
------------

// File: rtl/text_pixel_gen.sv
// Pixel generator for 640x480 VGA: renders "HELLO WORLD" plus a blinking block cursor
// from an internal 8x16 font, with a 3-stage pipeline and sync outputs delayed to match.
module text_pixel_gen #(
    parameter int unsigned TEXT_X0      = 256,
    parameter int unsigned TEXT_Y0      = 232,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter int unsigned NUM_CHARS    = 11,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h000
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        frame_start
);

    localparam int unsigned BOX_W  = ((NUM_CHARS + 1) * 8) << SCALE_LOG2;
    localparam int unsigned BOX_H  = 16 << SCALE_LOG2;
    localparam int unsigned CELL_W = $clog2(NUM_CHARS + 1);
    localparam int unsigned CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [3:0] {
        G_SPACE, G_H, G_E, G_L, G_O, G_W, G_R, G_D, G_CURSOR
    } glyph_t;

    // Glyph bitmaps, row 0 in the top byte
    localparam logic [127:0] FONT_H = 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
    localparam logic [127:0] FONT_E = 128'h0000_FE66_6268_7868_6062_66FE_0000_0000;
    localparam logic [127:0] FONT_L = 128'h0000_F060_6060_6060_6062_66FE_0000_0000;
    localparam logic [127:0] FONT_O = 128'h0000_7CC6_C6C6_C6C6_C6C6_C67C_0000_0000;
    localparam logic [127:0] FONT_W = 128'h0000_C6C6_C6C6_D6D6_D6FE_EE6C_0000_0000;
    localparam logic [127:0] FONT_R = 128'h0000_FC66_6666_7C6C_6666_66E6_0000_0000;
    localparam logic [127:0] FONT_D = 128'h0000_F86C_6666_6666_6666_6CF8_0000_0000;

    function automatic logic [7:0] font_row(input glyph_t g, input logic [3:0] r);
        logic [127:0] bm;
        case (g)
            G_H:      bm = FONT_H;
            G_E:      bm = FONT_E;
            G_L:      bm = FONT_L;
            G_O:      bm = FONT_O;
            G_W:      bm = FONT_W;
            G_R:      bm = FONT_R;
            G_D:      bm = FONT_D;
            G_CURSOR: bm = '1;
            default:  bm = '0;
        endcase
        return bm[(15 - r) * 8 +: 8];
    endfunction

    // Stage 1: box-relative coordinates
    logic [10:0]       dx, dy;
    logic              in_box_c;
    logic [CELL_W-1:0] s1_cell;
    logic [2:0]        s1_col;
    logic [3:0]        s1_row;
    logic              s1_in_box, s1_von, s1_hs, s1_vs;

    assign dx       = {1'b0, x} - 11'(TEXT_X0);
    assign dy       = {1'b0, y} - 11'(TEXT_Y0);
    assign in_box_c = (dx < 11'(BOX_W)) && (dy < 11'(BOX_H));

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            s1_cell   <= '0;
            s1_col    <= '0;
            s1_row    <= '0;
            s1_in_box <= 1'b0;
            s1_von    <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
        end else if (p_tick) begin
            s1_cell   <= dx[3 + SCALE_LOG2 +: CELL_W];
            s1_col    <= dx[SCALE_LOG2 +: 3];
            s1_row    <= dy[SCALE_LOG2 +: 4];
            s1_in_box <= in_box_c;
            s1_von    <= video_on;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
        end
    end

    // Stage 2: string ROM then font ROM
    glyph_t glyph;

    always_comb begin
        glyph = G_SPACE;
        case (32'(s1_cell))
            0:       glyph = G_H;
            1:       glyph = G_E;
            2, 3:    glyph = G_L;
            4:       glyph = G_O;
            5:       glyph = G_SPACE;
            6:       glyph = G_W;
            7:       glyph = G_O;
            8:       glyph = G_R;
            9:       glyph = G_L;
            10:      glyph = G_D;
            default: glyph = G_SPACE;
        endcase
        if (s1_cell == CELL_W'(NUM_CHARS))
            glyph = G_CURSOR;
    end

    logic [7:0] s2_byte;
    logic [2:0] s2_col;
    logic       s2_cursor, s2_in_box, s2_von, s2_hs, s2_vs;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            s2_byte   <= '0;
            s2_col    <= '0;
            s2_cursor <= 1'b0;
            s2_in_box <= 1'b0;
            s2_von    <= 1'b0;
            s2_hs     <= 1'b0;
            s2_vs     <= 1'b0;
        end else if (p_tick) begin
            s2_byte   <= font_row(glyph, s1_row);
            s2_col    <= s1_col;
            s2_cursor <= (glyph == G_CURSOR);
            s2_in_box <= s1_in_box;
            s2_von    <= s1_von;
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;
        end
    end

    // Stage 3: pixel select, cursor gating, blanking
    logic blink;
    logic pix;

    assign pix = s2_byte[3'd7 - s2_col] & (~s2_cursor | blink);

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            rgb   <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (p_tick) begin
            rgb   <= !s2_von ? '0 : (s2_in_box && pix) ? FG_RGB : BG_RGB;
            hsync <= s2_hs;
            vsync <= s2_vs;
        end
    end

    // Frame edge detect and blink timing run every clk, independent of p_tick
    logic             vs_d;
    logic [CNT_W-1:0] frame_cnt;

    assign frame_start = vsync_in & ~vs_d & reset_n;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            vs_d      <= 1'b0;
            frame_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            vs_d <= vsync_in;
            if (frame_start) begin
                if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
